// File: rtl/horiz_timing_gen.sv
// Horizontal VGA timing generator: divides pclk into a pixel tick, counts columns
// across a line and produces hsync, h_active and a one-cycle line_end strobe.
module horiz_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int DIV      = 4,
    parameter bit SYNC_POL = 1'b0,
    parameter int WIDTH    = 10
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             run,
    output logic [WIDTH-1:0] Hcnt,
    output logic             pix_tick,
    output logic             line_end,
    output logic             hsync,
    output logic             h_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0]    DIV_LAST    = DW'(DIV - 1);
    localparam logic [WIDTH-1:0] COL_LAST    = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] FRONT_START = WIDTH'(H_ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_START  = WIDTH'(H_ACTIVE + H_FP);
    localparam logic [WIDTH-1:0] BACK_START  = WIDTH'(H_ACTIVE + H_FP + H_SYNC);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_div_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic             r_hsync;
    logic             r_h_active;

    logic             w_tick;
    logic             w_last_col;
    logic [WIDTH-1:0] w_hcnt_nxt;
    state_t           w_state_nxt;

    // Phase owning a column; an empty phase has coincident bounds and is never selected.
    function automatic state_t phase_of(input logic [WIDTH-1:0] col);
        if (col < FRONT_START)     return ST_ACTIVE;
        else if (col < SYNC_START) return ST_FRONT;
        else if (col < BACK_START) return ST_SYNC;
        else                       return ST_BACK;
    endfunction

    assign w_tick      = run && (r_div_cnt == DIV_LAST);
    assign w_last_col  = (r_hcnt == COL_LAST);
    assign w_hcnt_nxt  = w_last_col ? '0 : r_hcnt + 1'b1;
    assign w_state_nxt = phase_of(w_hcnt_nxt);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_div_cnt  <= '0;
            r_hcnt     <= '0;
            r_state    <= ST_ACTIVE;
            r_hsync    <= ~SYNC_POL;
            r_h_active <= 1'b1;
        end else begin
            if (run) begin
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            end
            // Column, phase and the phase-decoded outputs all move on the same tick edge.
            if (w_tick) begin
                r_hcnt     <= w_hcnt_nxt;
                r_state    <= w_state_nxt;
                r_hsync    <= (w_state_nxt == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
                r_h_active <= (w_state_nxt == ST_ACTIVE);
            end
        end
    end

    assign Hcnt     = r_hcnt;
    assign pix_tick = w_tick;
    assign line_end = w_tick && w_last_col;
    assign hsync    = r_hsync;
    assign h_active = r_h_active;

endmodule

// File: tb/tb_horiz_timing_gen.sv
// Bench for horiz_timing_gen: a default 640x(800) instance against an arithmetic
// reference model, plus a small DIV=1 configuration driven from a vector table.
module tb_horiz_timing_gen;

    localparam int DIV     = 4;
    localparam int H_TOTAL = 800;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic       rst, run;
    logic [9:0] Hcnt;
    logic       pix_tick, line_end, hsync, h_active;

    logic       rst_s, run_s;
    logic [3:0] hcnt_s;
    logic       tick_s, lend_s, hs_s, ha_s;

    horiz_timing_gen dut (
        .pclk(pclk), .rst(rst), .run(run), .Hcnt(Hcnt), .pix_tick(pix_tick),
        .line_end(line_end), .hsync(hsync), .h_active(h_active)
    );

    horiz_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2), .DIV(1), .SYNC_POL(1'b0), .WIDTH(4)
    ) dut_s (
        .pclk(pclk), .rst(rst_s), .run(run_s), .Hcnt(hcnt_s), .pix_tick(tick_s),
        .line_end(lend_s), .hsync(hs_s), .h_active(ha_s)
    );

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    longint n        = 0;
    bit     mon_en   = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    // Reference: n = number of clock edges with run=1 since reset; everything follows from it.
    always @(posedge pclk or posedge rst) begin
        if (rst)      n <= 0;
        else if (run) n <= n + 1;
    end

    function automatic logic [13:0] model_out(input longint cnt, input logic r, input logic rs);
        int   col;
        logic t, le, hs, ha;
        col = int'((cnt / DIV) % H_TOTAL);
        t   = !rs && r && ((cnt % DIV) == DIV - 1);
        le  = t && (col == H_TOTAL - 1);
        hs  = !(col >= 656 && col < 752);
        ha  = (col < 640);
        return {10'(col), t, le, hs, ha};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge pclk) begin
        if (mon_en) begin
            logic [13:0] exp_v, act_v;
            exp_v = model_out(n, run, rst);
            act_v = {Hcnt, pix_tick, line_end, hsync, h_active};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                failures = failures + 1;
                $display("FAIL model {Hcnt,tick,le,hs,ha} actual=%h required=%h cyc=%0d",
                         act_v, exp_v, cyc);
            end
        end
    end

    // Returns at the negedge where Hcnt==col (and pix_tick, if asked); a timeout counts as a failure.
    task automatic wait_col(input int col, input bit need_tick);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge pclk);
            if (Hcnt == 10'(col) && (!need_tick || pix_tick)) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("reach_col_%0d", col), 32'(ok), 32'd1);
    endtask

    task automatic release_check();
        @(posedge pclk);
        #2 rst = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            chk($sformatf("first_tick_c%0d", k), 32'(pix_tick), 32'(k == 3));
            chk($sformatf("first_tick_hcnt_c%0d", k), 32'(Hcnt), 32'd0);
        end
        @(negedge pclk);
        chk("hcnt_after_first_tick", 32'(Hcnt), 32'd1);
    endtask

    typedef struct {
        logic       run;
        logic [3:0] hcnt;
        logic       tick;
        logic       lend;
        logic       hs;
        logic       ha;
    } vec_t;

    vec_t tab[16];
    int   c1, c2;

    initial begin
        tab[0]  = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[1]  = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[2]  = '{1'b1, 4'd2,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[3]  = '{1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[4]  = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[5]  = '{1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[6]  = '{1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b1};
        tab[7]  = '{1'b1, 4'd5,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[8]  = '{1'b1, 4'd6,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[9]  = '{1'b1, 4'd7,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[10] = '{1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b0};
        tab[11] = '{1'b1, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0};
        tab[12] = '{1'b1, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[13] = '{1'b1, 4'd11, 1'b1, 1'b1, 1'b1, 1'b0};
        tab[14] = '{1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b1};
        tab[15] = '{1'b1, 4'd1,  1'b1, 1'b0, 1'b1, 1'b1};

        rst   = 1'b1;
        run   = 1'b1;
        rst_s = 1'b1;
        run_s = 1'b0;
        repeat (3) @(posedge pclk);

        // Small configuration: one vector per cycle, applied just after the falling edge.
        @(negedge pclk);
        rst_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge pclk);
            run_s = tab[i].run;
            #1;
            chk($sformatf("small_v%0d", i),
                32'({hcnt_s, tick_s, lend_s, hs_s, ha_s}),
                32'({tab[i].hcnt, tab[i].tick, tab[i].lend, tab[i].hs, tab[i].ha}));
        end
        run_s = 1'b0;

        // Default instance: reset values while held in reset with run=1.
        @(negedge pclk);
        mon_en = 1'b1;
        chk("rst_hcnt", 32'(Hcnt), 32'd0);
        chk("rst_tick", 32'(pix_tick), 32'd0);
        chk("rst_line_end", 32'(line_end), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_h_active", 32'(h_active), 32'd1);
        release_check();

        wait_col(639, 1'b1);
        chk("h_active_at_639", 32'(h_active), 32'd1);
        @(negedge pclk);
        chk("h_active_at_640", 32'({Hcnt, h_active}), 32'({10'd640, 1'b0}));
        wait_col(655, 1'b1);
        chk("hsync_at_655", 32'(hsync), 32'd1);
        @(negedge pclk);
        chk("hsync_at_656", 32'({Hcnt, hsync}), 32'({10'd656, 1'b0}));
        wait_col(751, 1'b1);
        chk("hsync_at_751", 32'(hsync), 32'd0);
        @(negedge pclk);
        chk("hsync_at_752", 32'({Hcnt, hsync}), 32'({10'd752, 1'b1}));
        wait_col(799, 1'b1);
        c1 = cyc;
        chk("line_end_at_799", 32'(line_end), 32'd1);
        @(negedge pclk);
        chk("wrap_to_0", 32'({Hcnt, line_end, h_active}), 32'({10'd0, 1'b0, 1'b1}));
        wait_col(799, 1'b1);
        c2 = cyc;
        chk("line_period", 32'(c2 - c1), 32'd3200);

        // Pause with div_cnt=2 at column 300.
        wait_col(299, 1'b1);
        repeat (3) @(posedge pclk);
        #2 run = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge pclk);
            chk("pause_frozen", 32'({Hcnt, pix_tick, line_end, hsync, h_active}),
                32'({10'd300, 1'b0, 1'b0, 1'b1, 1'b1}));
        end
        @(posedge pclk);
        #2 run = 1'b1;
        @(negedge pclk);
        chk("resume_c0_tick", 32'(pix_tick), 32'd0);
        @(negedge pclk);
        chk("resume_c1_tick", 32'({Hcnt, pix_tick}), 32'({10'd300, 1'b1}));
        @(negedge pclk);
        chk("resume_hcnt", 32'(Hcnt), 32'd301);

        // Asynchronous reset in the middle of the sync pulse.
        wait_col(700, 1'b0);
        chk("mid_sync_hsync", 32'(hsync), 32'd0);
        @(posedge pclk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_hcnt", 32'(Hcnt), 32'd0);
        chk("async_rst_hsync", 32'(hsync), 32'd1);
        chk("async_rst_h_active", 32'(h_active), 32'd1);
        repeat (2) @(posedge pclk);
        release_check();

        // Randomised run gaps and occasional resets, checked by the reference model.
        repeat (9000) begin
            @(posedge pclk);
            #2;
            run = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 1999) == 0);
        end
        @(posedge pclk);
        #2 rst = 1'b0;
        @(negedge pclk);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
